// File: rtl/qarctan_pipe.sv
// qarctan_pipe: fixed-point quadrant arctangent for the FM demodulator path.
//
// Returns angle(x + jy) in radians with FRAC_BITS fraction bits, using the
// first-order approximation angle ~= base - QUAD_ONE * r, where
//   x >= 0 : r = (x - |y|) / (x + |y|), base = QUAD_ONE   (pi/4)
//   x <  0 : r = (x + |y|) / (|y| - x), base = QUAD_THREE (3pi/4)
// and the result is negated for y < 0. The quotient comes from an internal
// restoring divider producing one bit per cycle, so one sample is in flight
// at a time. A sideband tag travels with the sample so several channels can
// share one unit.
//
// Ports:
//   clk        clock, everything on the rising edge
//   reset      synchronous, active-high
//   in_valid   x, y, in_tag valid
//   in_ready   unit is idle and accepts a sample
//   x, y       signed WIDTH-bit complex sample
//   in_tag     TAG_WIDTH sideband tag
//   out_valid  angle, out_tag valid (held until out_ready)
//   out_ready  downstream accepts the result
//   angle      signed WIDTH-bit angle, FRAC_BITS fraction bits
//   out_tag    tag of the sample that produced angle
//
// Build option: define QARCTAN_ROUND_EN to run one extra divider cycle for a
// guard bit and round both the quotient and the final product half away
// from zero (latency FRAC_BITS+5 instead of FRAC_BITS+4).

module qarctan_pipe #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 10,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     angle,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int QUAD_ONE   = int'(3.14159265358979323846 / 4.0 * real'(2 ** FRAC_BITS));
  localparam int QUAD_THREE = 3 * QUAD_ONE;

`ifdef QARCTAN_ROUND_EN
  localparam int QB = FRAC_BITS + 3;  // quotient bits incl. guard bit
`else
  localparam int QB = FRAC_BITS + 2;
`endif
  localparam int CW = $clog2(QB);
  localparam int WW = WIDTH + 2;          // width of the setup sums
  localparam int DW = WIDTH + 1;          // divisor fits: den < 2^(WIDTH+1)
  localparam int PW = 2 * FRAC_BITS + 3;  // QUAD_ONE * q, both <= 2^FRAC_BITS

  localparam logic signed [WW-1:0] Y_MAX = WW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic [WIDTH-1:0]     Y_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SETUP, DIV, POST, HOLD} state_t;

  state_t                 state;
  logic signed [WIDTH-1:0] x_r, y_r;
  logic [TAG_WIDTH-1:0]   tag_r;
  logic                   neg_num;
  logic [DW-1:0]          den_r;
  logic [DW-1:0]          part;    // partial remainder, always < den_r
  logic [QB-1:0]          dbits;   // low dividend bits still to shift in
  logic [QB-1:0]          qbits;
  logic [CW-1:0]          cnt;

  // ---------------- setup: operand conditioning ----------------
  logic signed [WW-1:0] x_e, y_e, y_mag, ay, num_s, den_s, num_mag;

  // NOTE: always_comb uses blocking assignments with a default for every
  // output first, so each path assigns every signal and no latch is inferred.
  always_comb begin
    x_e   = WW'(x_r);
    y_e   = WW'(y_r);
    y_mag = y_r[WIDTH-1] ? -y_e : y_e;
    if (y_r == Y_MIN) y_mag = Y_MAX;
    // +1 keeps den strictly positive, so x=y=0 needs no special case.
    ay = y_mag + WW'(1);
    if (!x_r[WIDTH-1]) begin
      num_s = x_e - ay;
      den_s = x_e + ay;
    end else begin
      num_s = x_e + ay;
      den_s = ay - x_e;
    end
    num_mag = num_s[WW-1] ? -num_s : num_s;
  end

  // ---------------- divider step ----------------
  // Dividend is |num| << (QB-2). Its bits above position QB-1 are |num| >> 2,
  // which seed the partial remainder; the rest stream in one per cycle.
  logic [DW:0]   trial;
  logic          ge;
  logic [DW-1:0] part_next;

  always_comb begin
    trial     = {part, dbits[QB-1]};
    ge        = (trial >= {1'b0, den_r});
    part_next = DW'(ge ? trial - {1'b0, den_r} : trial);
  end

  // ---------------- post: signed quotient to angle ----------------
  logic [QB-1:0]        q_mag;
  logic signed [PW-1:0] q_s, prod, p, a, ang;

  always_comb begin
`ifdef QARCTAN_ROUND_EN
    q_mag = (qbits + QB'(1)) >> 1;
`else
    q_mag = qbits;
`endif
    q_s  = neg_num ? -signed'(PW'(q_mag)) : signed'(PW'(q_mag));
    prod = q_s * PW'(QUAD_ONE);
`ifdef QARCTAN_ROUND_EN
    p = prod[PW-1] ? -prod : prod;
    p = (p + PW'(2 ** (FRAC_BITS - 1))) >>> FRAC_BITS;
    if (prod[PW-1]) p = -p;
`else
    p = prod >>> FRAC_BITS;
`endif
    a   = (x_r[WIDTH-1] ? PW'(QUAD_THREE) : PW'(QUAD_ONE)) - p;
    ang = y_r[WIDTH-1] ? -a : a;
  end

  // ---------------- control and state ----------------
  // NOTE: every register, datapath included, is cleared on reset so that an
  // aborted sample leaves no trace in angle/out_tag or in the divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      angle     <= '0;
      out_tag   <= '0;
      x_r       <= '0;
      y_r       <= '0;
      tag_r     <= '0;
      neg_num   <= 1'b0;
      den_r     <= '0;
      part      <= '0;
      dbits     <= '0;
      qbits     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r      <= x;
            y_r      <= y;
            tag_r    <= in_tag;
            in_ready <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          neg_num <= num_s[WW-1];
          den_r   <= DW'(den_s);
          part    <= DW'(num_mag >>> 2);
          dbits   <= {num_mag[1:0], {(QB-2){1'b0}}};
          qbits   <= '0;
          cnt     <= '0;
          state   <= DIV;
        end
        DIV: begin
          part  <= part_next;
          dbits <= dbits << 1;
          qbits <= {qbits[QB-2:0], ge};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(QB - 1)) state <= POST;
        end
        POST: begin
          angle     <= WIDTH'(ang);
          out_tag   <= tag_r;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qarctan_pipe.sv
// Testbench for qarctan_pipe at default parameters. A reference model
// computes each expected angle straight from the arctangent formula with
// 64-bit integer arithmetic; a compare process checks every cycle that
// out_valid is high against the head of the expected queue.

module tb_qarctan_pipe;

  localparam int W = 32;
  localparam int F = 10;
  localparam int T = 4;
  localparam longint Q1 = 804;  // round(pi/4 * 1024)
`ifdef QARCTAN_ROUND_EN
  localparam int LAT = F + 5;
`else
  localparam int LAT = F + 4;
`endif
  // accept edge, result edge LAT, release edge LAT+1, next accept LAT+2
  localparam int PERIOD = LAT + 2;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic signed [W-1:0] x, y;
  logic [T-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] angle;
  logic [T-1:0] out_tag;

  qarctan_pipe #(.WIDTH(W), .FRAC_BITS(F), .TAG_WIDTH(T)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .angle(angle), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { longint ang; logic [T-1:0] tag; } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // angle(x+jy) from the approximation, independent of any hardware detail.
  function automatic longint model_angle(input longint xv, input longint yv);
    longint ay, num, den, mag, q, prod, p, base, a;
    longint most_neg = -(64'sd1 <<< (W - 1));
    ay = (yv == most_neg) ? -(most_neg + 1) : (yv < 0 ? -yv : yv);
    ay = ay + 1;
    if (xv >= 0) begin num = xv - ay; den = xv + ay; base = Q1; end
    else begin num = xv + ay; den = ay - xv; base = 3 * Q1; end
    mag = (num < 0) ? -num : num;
`ifdef QARCTAN_ROUND_EN
    q = (((mag * (64'sd1 <<< (F + 1))) / den) + 1) / 2;
`else
    q = (mag * (64'sd1 <<< F)) / den;
`endif
    if (num < 0) q = -q;
    prod = Q1 * q;
`ifdef QARCTAN_ROUND_EN
    p = (prod < 0) ? -((-prod + (64'sd1 <<< (F - 1))) >>> F)
                   : ((prod + (64'sd1 <<< (F - 1))) >>> F);
`else
    p = prod >>> F;
`endif
    a = base - p;
    return (yv < 0) ? -a : a;
  endfunction

  // Compare process: #1 after the falling edge so stimulus written on that
  // edge (out_ready, reset) is already visible.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", longint'(out_valid), 0);
        end else begin
          check("angle", longint'($signed(angle)), exp_q[0].ang);
          check("out_tag", longint'(out_tag), longint'(exp_q[0].tag));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  int acc_cyc;

  task automatic send(input logic signed [W-1:0] xs, input logic signed [W-1:0] ys,
                      input logic [T-1:0] t);
    int n = 0;
    exp_t e;
    @(negedge clk);
    x = xs; y = ys; in_tag = t; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", longint'(in_ready), 1);
    @(posedge clk);
    e.ang = model_angle(longint'(xs), longint'(ys));
    e.tag = t;
    exp_q.push_back(e);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_within_budget", longint'(out_valid), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drained", longint'(exp_q.size()), 0);
  endtask

  task automatic directed(input logic signed [W-1:0] xs, input logic signed [W-1:0] ys,
                          input logic [T-1:0] t, input longint lit);
    send(xs, ys, t);
    wait_valid(LAT + 10);
    check("latency", longint'(cyc - acc_cyc), LAT);
`ifndef QARCTAN_ROUND_EN
    check("literal_angle", longint'($signed(angle)), lit);
    check("literal_model", model_angle(longint'(xs), longint'(ys)), lit);
`endif
    wait_drain(10);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_angle", longint'(angle), 0);
    check("rst_out_tag", longint'(out_tag), 0);
    reset = 1'b0;

    // Hand-computed vectors.
    directed(32'sd1024, 32'sd0, 4'd3, 2);
    check("tag_first", longint'(out_tag), 3);
    directed(32'sd0, 32'sd0, 4'd1, 1608);
    directed(32'sd0, 32'sd1024, 4'd2, 1608);
    directed(-32'sd1024, -32'sd1, 4'd4, -3213);

    // Backpressure: result held for 20 cycles, new sample ignored.
    out_ready = 1'b0;
    send(32'sd500, -32'sd300, 4'd5);
    wait_valid(LAT + 10);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; x = 32'sd7; y = 32'sd7; in_tag = 4'd9;
      check("stall_in_ready", longint'(in_ready), 0);
      check("stall_out_valid", longint'(out_valid), 1);
      check("stall_out_tag", longint'(out_tag), 5);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", longint'(out_valid), 0);
    check("release_in_ready", longint'(in_ready), 1);
    repeat (LAT + 6) @(negedge clk);
    check("stall_sample_dropped", longint'(out_valid), 0);
    check("stall_queue_empty", longint'(exp_q.size()), 0);

    // Reset while the divider is running.
    send(32'sd1000, 32'sd2000, 4'd6);
    while (cyc < acc_cyc + 5) @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; x = 32'sd3; y = 32'sd4; in_tag = 4'd7;  // reset wins
    @(negedge clk);
    exp_q.delete();
    check("div_rst_out_valid", longint'(out_valid), 0);
    check("div_rst_angle", longint'(angle), 0);
    check("div_rst_in_ready", longint'(in_ready), 1);
    check("div_rst_out_tag", longint'(out_tag), 0);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_vs_valid_not_accepted", longint'(in_ready), 1);
    repeat (LAT + 10) @(negedge clk);
    check("no_stale_result", longint'(out_valid), 0);

    // Back-to-back with extreme operands; the compare process checks values
    // and tag order, here the accept spacing is checked.
    begin
      logic signed [W-1:0] xv[8];
      logic signed [W-1:0] yv[8];
      int prev;
      xv = '{32'sh7fffffff, 32'sd12345, -32'sd77,      32'sh80000000,
             32'sd0,        -32'sd5000, 32'sh7fffffff, 32'sd31};
      yv = '{32'sd12345,    32'sh80000000, 32'sd999,   32'sh7fffffff,
             -32'sd1,       -32'sd5000,    32'sh80000000, -32'sd1000};
      for (int i = 0; i < 8; i++) begin
        send(xv[i], yv[i], T'(i + 8));
        if (i > 0) check("b2b_spacing", longint'(acc_cyc - prev), PERIOD);
        prev = acc_cyc;
      end
      wait_drain(PERIOD + 10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule
